key_rx_fifo: RTL and testbench

Keyboard receive buffer between the PS/2 decoder and the CPU bus/interrupt path.
- Captures each new ASCII code from the decoder into a small FIFO.
- Exposes a data register (pop on read) and a status register to the bus read mux.
- Raises interrupt_vector while characters are pending, with an ack/re-arm handshake.
- Replaces direct sampling of the decoder's live ascii output, so keystrokes arriving faster than the slow CPU clock are not lost.

---
 rtl/key_rx_fifo_pkg.sv | 35 +++
 rtl/key_rx_fifo_sync_fifo.sv | 53 +++++
 rtl/key_rx_fifo.sv | 121 ++++++++++++
 tb/tb_key_rx_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/key_rx_fifo_pkg.sv
// Shared constants for the keyboard receive buffer: bus addresses, status
// bit layout, default IRQ vector and the IRQ FSM state type.
package key_rx_fifo_pkg;

  localparam logic [31:0] KEY_BASE   = 32'h0000_2000;
  localparam logic [31:0] KEY_DATA   = KEY_BASE + 32'h0;
  localparam logic [31:0] KEY_STATUS = KEY_BASE + 32'h8;

  localparam int unsigned STAT_VALID   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  localparam logic [3:0] KEY_IRQ_VEC = 4'd1;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_PEND,
    IRQ_ACKED
  } irq_state_t;

  function automatic logic [63:0] status_word(input logic [7:0] cnt,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       valid);
    logic [63:0] w;
    w                     = '0;
    w[STAT_CNT_LSB +: 8]  = cnt;
    w[STAT_OVF]           = ovf;
    w[STAT_FULL]          = full;
    w[STAT_VALID]         = valid;
    return w;
  endfunction

endpackage

// File: rtl/key_rx_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop in the same cycle frees a
// slot for a push into a full FIFO.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign count   = wr_q - rd_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop)  rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/key_rx_fifo.sv
// Keyboard receive buffer: captures decoder keystrokes into a FIFO, serves
// data/status reads on the bus, and raises an ack/re-arm interrupt.
module key_rx_fifo
  import key_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter logic [3:0]  IRQ_VEC = KEY_IRQ_VEC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_pressed,
  input  logic [7:0]             ascii,
  input  logic                   bus_read_enable,
  input  logic                   sel_data,
  input  logic                   sel_status,
  output logic [63:0]            bus_read_data,
  output logic [3:0]             interrupt_vector,
  input  logic                   interrupt_ack,
  output logic [$clog2(DEPTH):0] count
);

  logic        kp_q, kp_d, ben_q, ben_d;
  logic        ovf_q, ovf_d;
  logic [63:0] rdata_q, rdata_d;
  logic        push, push_ok, rd_edge, data_rd, stat_rd, pop;
  logic        full, empty;
  logic [7:0]  head;

  irq_state_t  state_q;
  logic [3:0]  vec_q;
  logic        new_push_q;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (ascii),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    kp_d    = key_pressed;
    ben_d   = bus_read_enable;
    push    = key_pressed && !kp_q && (ascii != 8'h00);
    rd_edge = bus_read_enable && !ben_q;
    data_rd = rd_edge && sel_data;
    stat_rd = rd_edge && sel_status && !sel_data;
    pop     = data_rd && !empty;
    push_ok = push && (!full || pop);

    // Clear first so an overflow arriving with the status read stays set.
    ovf_d = ovf_q;
    if (stat_rd)                ovf_d = 1'b0;
    if (push && full && !pop)   ovf_d = 1'b1;

    rdata_d = rdata_q;
    if (data_rd)      rdata_d = {56'b0, empty ? 8'h00 : head};
    else if (stat_rd) rdata_d = status_word(8'(count), ovf_q, full, !empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kp_q    <= 1'b0;
      ben_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      kp_q    <= kp_d;
      ben_q   <= ben_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // ACKED re-arms only once ack drops and either the ISR drained the FIFO
  // or a key arrived during the ISR (the latter re-raises from IDLE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IRQ_IDLE;
      vec_q      <= '0;
      new_push_q <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          new_push_q <= 1'b0;
          if (!empty) begin
            state_q <= IRQ_PEND;
            vec_q   <= IRQ_VEC;
          end
        end
        IRQ_PEND: begin
          if (interrupt_ack) begin
            state_q <= IRQ_ACKED;
            vec_q   <= '0;
          end
        end
        IRQ_ACKED: begin
          vec_q <= '0;
          if (!interrupt_ack && (empty || new_push_q || push_ok)) begin
            state_q    <= IRQ_IDLE;
            new_push_q <= 1'b0;
          end else if (push_ok) begin
            new_push_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IRQ_IDLE;
          vec_q   <= '0;
        end
      endcase
    end
  end

  assign bus_read_data    = rdata_q;
  assign interrupt_vector = vec_q;

endmodule

// File: tb/tb_key_rx_fifo.sv
// Directed bench for key_rx_fifo: read results checked by a scoreboard
// monitor, occupancy and IRQ checked inline.
module tb_key_rx_fifo;

  logic        clk = 1'b0;
  logic        reset, key_pressed, bus_read_enable, sel_data, sel_status;
  logic        interrupt_ack;
  logic [7:0]  ascii;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic [3:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] sb [$];

  key_rx_fifo #(.DEPTH(8), .IRQ_VEC(4'd1)) dut (
    .clk              (clk),
    .reset            (reset),
    .key_pressed      (key_pressed),
    .ascii            (ascii),
    .bus_read_enable  (bus_read_enable),
    .sel_data         (sel_data),
    .sel_status       (sel_status),
    .bus_read_data    (bus_read_data),
    .interrupt_vector (interrupt_vector),
    .interrupt_ack    (interrupt_ack),
    .count            (count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every bus read edge yields a result 1 clk later.
  initial begin
    logic prev = 1'b0;
    logic cur;
    logic [63:0] exp;
    forever begin
      @(posedge clk);
      cur = bus_read_enable;
      if (reset) prev = 1'b0;
      else begin
        if (cur && !prev) begin
          #1;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_unexpected: got 0x%0h expected no read", bus_read_data);
          end else begin
            exp = sb.pop_front();
            chk("read_data", bus_read_data, exp);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic press(input logic [7:0] c, input int unsigned hold);
    key_pressed = 1'b1;
    ascii       = c;
    repeat (hold) @(negedge clk);
    key_pressed = 1'b0;
    ascii       = 8'h00;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic sd, input logic ss, input int unsigned hold,
                        input logic [63:0] exp);
    sb.push_back(exp);
    bus_read_enable = 1'b1;
    sel_data        = sd;
    sel_status      = ss;
    repeat (hold) @(negedge clk);
    bus_read_enable = 1'b0;
    sel_data        = 1'b0;
    sel_status      = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_pressed = 1'b0; ascii = 8'h00; bus_read_enable = 1'b0;
    sel_data = 1'b0; sel_status = 1'b0; interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_vec", 64'(interrupt_vector), 64'd0);
    chk("reset_rdata", bus_read_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 'a' held 100 cycles: one push, IRQ within 2 cycles
    key_pressed = 1'b1; ascii = 8'h61;
    repeat (2) @(negedge clk);
    chk("a_count", 64'(count), 64'd1);
    chk("a_vec", 64'(interrupt_vector), 64'd1);
    repeat (98) @(negedge clk);
    key_pressed = 1'b0; ascii = 8'h00;
    @(negedge clk);
    chk("a_held_count", 64'(count), 64'd1);
    bus_rd(1'b0, 1'b1, 1, 64'h0101);

    // long data strobe pops exactly one
    press(8'h62, 3);
    bus_rd(1'b1, 1'b0, 50, 64'h61);
    chk("long_rd_count", 64'(count), 64'd1);
    bus_rd(1'b1, 1'b0, 1, 64'h62);

    // ack in PEND, drained ISR: no re-raise
    interrupt_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("ack_vec", 64'(interrupt_vector), 64'd0);
    interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("drained_vec", 64'(interrupt_vector), 64'd0);
    press(8'h63, 1);
    chk("new_key_vec", 64'(interrupt_vector), 64'd1);

    // key during ISR re-raises after ack drops
    interrupt_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("ack2_vec", 64'(interrupt_vector), 64'd0);
    press(8'h64, 2);
    chk("isr_key_vec", 64'(interrupt_vector), 64'd0);
    interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rearm_vec", 64'(interrupt_vector), 64'd1);
    bus_rd(1'b1, 1'b0, 1, 64'h63);
    bus_rd(1'b1, 1'b0, 1, 64'h64);

    // empty read and non-printable key
    bus_rd(1'b1, 1'b0, 2, 64'h0);
    press(8'h00, 4);
    chk("ascii0_count", 64'(count), 64'd0);

    // overflow
    for (int i = 0; i < 9; i++) press(8'h30 + 8'(i), 2);
    chk("full_count", 64'(count), 64'd8);
    bus_rd(1'b0, 1'b1, 1, 64'h0807);
    bus_rd(1'b0, 1'b1, 1, 64'h0803);

    // full: push and pop in the same cycle
    sb.push_back(64'h30);
    key_pressed = 1'b1; ascii = 8'h41; bus_read_enable = 1'b1; sel_data = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0; ascii = 8'h00; bus_read_enable = 1'b0; sel_data = 1'b0;
    @(negedge clk);
    chk("full_pp_count", 64'(count), 64'd8);
    bus_rd(1'b0, 1'b1, 1, 64'h0803);

    // drain; one read with both selects (data wins)
    for (int i = 1; i < 8; i++) bus_rd(1'b1, (i == 3), 1, 64'h30 + 64'(i));
    bus_rd(1'b1, 1'b0, 1, 64'h41);
    chk("drained_count", 64'(count), 64'd0);

    // reset mid-operation
    for (int i = 0; i < 5; i++) press(8'h50 + 8'(i), 1);
    chk("pre_reset_count", 64'(count), 64'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_count", 64'(count), 64'd0);
    chk("mid_reset_vec", 64'(interrupt_vector), 64'd0);
    chk("mid_reset_rdata", bus_read_data, 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
